mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory between two requesters: the multicycle CPU
//  controller/datapath (port C) and the UART boot-loader/debug port (port D).
//  Sits between both masters and the memory macro. One access is in flight at a time.
//  Round-robin grant, with a fixed-CPU-priority option.
//  The CPU FSM stalls while c_req_i=1 and c_ack_o=0.
// PARAMETERS
//  ADDR_W   32  address width, byte address passed through unchanged
//  DATA_W   32  data width
//  MEM_LAT  1   memory read latency in cycles, >=1; rdata valid MEM_LAT cycles after the issue cycle
//  CPU_PRIO 0   1: port C always wins a tie; 0: round-robin
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high
//  c_req_i      in   1       CPU request; held with we/addr/wdata stable until c_ack_o
//  c_we_i       in   1       CPU write (1) / read (0)
//  c_addr_i     in   ADDR_W  CPU address
//  c_wdata_i    in   DATA_W  CPU write data
//  c_rdata_o    out  DATA_W  CPU read data, valid when c_ack_o=1, held afterwards
//  c_ack_o      out  1       one-cycle completion pulse
//  d_req_i/d_we_i/d_addr_i/d_wdata_i/d_rdata_o/d_ack_o   same as port C, for the debug/loader port
//  mem_en_o     out  1       memory command strobe, one cycle per access
//  mem_we_o     out  1       memory write enable, qualified by mem_en_o
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_rdata_i  in   DATA_W  memory read data
//  busy_o       out  1       1 in any state other than IDLE
// BEHAVIOUR
//  Reset:
//   - all outputs 0, state=IDLE, cnt=0.
//   - last_grant=D, so C wins the first tie.
//  States: IDLE -> ISSUE -> (read: WAIT) -> DONE -> IDLE.
//  IDLE:
//   - If any req: choose the winner.
//   - Latch the winner's we, addr and wdata into registers; go to ISSUE.
//   - Requests are sampled only in IDLE.
//  Arbitration:
//   - Single requester wins.
//   - On a tie with CPU_PRIO=1, C wins.
//   - On a tie with CPU_PRIO=0, the port != last_grant wins; last_grant updates at grant.
//  ISSUE:
//   - mem_en_o=1 for exactly one cycle, driven from the latched registers.
//   - Write: go to DONE.
//   - Read: cnt<=MEM_LAT-1, go to WAIT.
//  WAIT:
//   - If cnt==0: capture mem_rdata_i into the granted port's rdata register, go to DONE.
//   - Otherwise decrement cnt.
//  DONE:
//   - Granted port's ack=1 for one cycle, go to IDLE.
//   - The other port's rdata is untouched.
//  mem_*_o other than mem_en_o hold the latched values and are don't-care when mem_en_o=0.
//  Latency, req seen in IDLE at cycle 0:
//   - Write: mem_en at cycle 1, ack at cycle 2.
//   - Read: ack at cycle MEM_LAT+2.
//  Back-to-back:
//   - The earliest next grant is the IDLE cycle after DONE.
//   - A req still high in that IDLE cycle is a NEW request; requesters drop req in the cycle after ack.
//  Other requester waits with no ack and no side effects.
//  req dropped mid-transaction:
//   - The access still completes and ack still pulses.
//   - Requesters must not do this.
//  Reset mid-transaction:
//   - Immediate return to IDLE with all outputs 0.
//   - An already-issued write may have landed in memory.
//   - No ack is ever produced for the aborted access.
//  Both ack outputs are never 1 in the same cycle; mem_en_o is never 1 outside ISSUE.
// STRUCTURE
//  defines.v:
//   - ARB_STATE_WIDTH and ARB_STATE_IDLE/ISSUE/WAIT/DONE.
//   - ARB_PORT_C=0 and ARB_PORT_D=1.
//  Single module:
//   - state register plus next-state always block.
//   - grant/last_grant logic.
//   - latched command registers and latency counter (width $clog2(MEM_LAT+1)).
//   - two rdata registers.
//  No sub-module.
// TESTING
//  1. C read, addr=0x10, mem model returns 0xDEADBEEF, MEM_LAT=1
//     -> mem_en at cycle 1, c_ack at cycle 3, c_rdata=0xDEADBEEF; d_ack and d_rdata stay 0.
//  2. D write, addr=0x20, data=0x12345678
//     -> mem_en&mem_we at cycle 1 with addr=0x20, data=0x12345678; d_ack at cycle 2; busy_o=1 during cycles 1-2.
//  3. C and D read both held high for 4 transactions, CPU_PRIO=0
//     -> grants C,D,C,D; acks never overlap.
//     With CPU_PRIO=1, C is granted on every tie while C keeps requesting.
//  4. MEM_LAT=3, C read
//     -> c_ack at cycle 5; mem_rdata_i sampled exactly at cycle 4; a rdata change at cycle 3 must not be captured.
//  5. rst asserted during WAIT of a D read -> next cycle IDLE, all outputs 0, no d_ack.
//     A C req after release -> normal cycle-0 timing.
//  6. D requests one cycle after C is granted -> D waits.
//     D is granted in the IDLE cycle after c_ack; d_ack at 2/MEM_LAT+2 cycles later.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and arbitration helper for the unified-memory arbiter.
// Port C is the multicycle CPU, port D the UART boot-loader/debug master.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } arb_port_e;

  // Winner among the pending requesters; only meaningful when at least one requests.
  function automatic arb_port_e pick_winner(input logic      c_req,
                                            input logic      d_req,
                                            input arb_port_e last_grant,
                                            input logic      cpu_prio);
    if (c_req && d_req) begin
      if (cpu_prio) return PORT_C;
      return (last_grant == PORT_C) ? PORT_D : PORT_C;
    end
    if (d_req) return PORT_D;
    return PORT_C;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single memory macro; one access in flight at a time.
// Round-robin on ties, or fixed CPU priority when CPU_PRIO=1.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned CPU_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  output logic [DATA_W-1:0] c_rdata_o,
  output logic              c_ack_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  arb_state_e       state;
  arb_port_e        grant;
  arb_port_e        last_grant;
  arb_port_e        winner;
  logic [CNT_W-1:0] cnt;

  assign winner = pick_winner(c_req_i, d_req_i, last_grant, CPU_PRIO != 0);

  // NOTE: every register here is state updated on the clock edge, so only non-blocking
  // assignments are used; a blocking write would leak the new value into later reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the command and read-data registers are reset too, because the outputs
      // they drive must read 0 straight out of reset, not just the control state.
      state       <= ST_IDLE;
      grant       <= PORT_C;
      last_grant  <= PORT_D;
      cnt         <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      c_rdata_o   <= '0;
      d_rdata_o   <= '0;
      c_ack_o     <= 1'b0;
      d_ack_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      mem_en_o <= 1'b0;
      c_ack_o  <= 1'b0;
      d_ack_o  <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (c_req_i || d_req_i) begin
            grant      <= winner;
            last_grant <= winner;
            if (winner == PORT_D) begin
              mem_we_o    <= d_we_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
            end else begin
              mem_we_o    <= c_we_i;
              mem_addr_o  <= c_addr_i;
              mem_wdata_o <= c_wdata_i;
            end
            mem_en_o <= 1'b1;
            busy_o   <= 1'b1;
            state    <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (mem_we_o) begin
            c_ack_o <= (grant == PORT_C);
            d_ack_o <= (grant == PORT_D);
            state   <= ST_DONE;
          end else begin
            cnt   <= CNT_W'(MEM_LAT - 1);
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (cnt == '0) begin
            // Only the granted port's read data moves; the other keeps its last value.
            if (grant == PORT_C) c_rdata_o <= mem_rdata_i;
            else                 d_rdata_o <= mem_rdata_i;
            c_ack_o <= (grant == PORT_C);
            d_ack_o <= (grant == PORT_D);
            state   <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 is MEM_LAT=1/round-robin,
// instance 1 is MEM_LAT=3/CPU priority; both have a latency-exact memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req       [2][2];
  logic        we        [2][2];
  logic [31:0] addr      [2][2];
  logic [31:0] wdata     [2][2];
  logic [31:0] rdata     [2][2];
  logic        ack       [2][2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        busy      [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          en_cyc;
    int          ack_cyc;
  } txn_t;

  txn_t        cmd_q[$];
  txn_t        ack_q[$];
  logic [31:0] shadow [2][2];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rdata_drv = 32'hBAD0_0000;
    logic [31:0] val = '0;
    int          due = -1;
    bit          loaded = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CPU_PRIO(g)) u_dut (
      .clk(clk), .rst(rst[g]),
      .c_req_i(req[g][0]), .c_we_i(we[g][0]), .c_addr_i(addr[g][0]), .c_wdata_i(wdata[g][0]),
      .c_rdata_o(rdata[g][0]), .c_ack_o(ack[g][0]),
      .d_req_i(req[g][1]), .d_we_i(we[g][1]), .d_addr_i(addr[g][1]), .d_wdata_i(wdata[g][1]),
      .d_rdata_o(rdata[g][1]), .d_ack_o(ack[g][1]),
      .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(rdata_drv), .busy_o(busy[g])
    );

    // Read data is valid only in the cycle exactly LAT after the issue cycle; garbage otherwise.
    always @(negedge clk) begin
      if (!loaded) begin
        mem[32'h10] = 32'hDEAD_BEEF;
        mem[32'h14] = 32'h1414_1414;
        mem[32'h18] = 32'h1818_1818;
        mem[32'h1C] = 32'h1C1C_1C1C;
        mem[32'h40] = 32'hCAFE_F00D;
        mem[32'h44] = 32'h4444_4444;
        mem[32'h48] = 32'h4848_4848;
        mem[32'h4C] = 32'h4C4C_4C4C;
        loaded = 1'b1;
      end
      rdata_drv = (cyc == due) ? val : (32'hBAD0_0000 | 32'(cyc & 16'hFFFF));
      if (mem_en[g]) begin
        if (mem_we[g]) mem[mem_addr[g]] = mem_wdata[g];
        else begin
          due = cyc + LAT;
          val = mem.exists(mem_addr[g]) ? mem[mem_addr[g]] : 32'hBAD0_0000;
        end
      end
    end
  end

  txn_t mon_e;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        shadow[i][0] = '0;
        shadow[i][1] = '0;
      end else begin
        if (mem_en[i]) begin
          if (cmd_q.size() == 0) check("unexpected_mem_en", 32'(i), 32'hFFFF_FFFF);
          else begin
            mon_e = cmd_q.pop_front();
            check("en_inst",   32'(i),            32'(mon_e.inst));
            check("en_cycle",  32'(cyc),          32'(mon_e.en_cyc));
            check("mem_we",    32'(mem_we[i]),    32'(mon_e.we));
            check("mem_addr",  mem_addr[i],       mon_e.addr);
            if (mon_e.we) check("mem_wdata", mem_wdata[i], mon_e.wdata);
          end
        end
        if (ack[i][0] && ack[i][1]) check("ack_overlap", 32'd1, 32'd0);
        for (int p = 0; p < 2; p++) begin
          if (ack[i][p]) begin
            if (ack_q.size() == 0) check("unexpected_ack", 32'(i * 2 + p), 32'hFFFF_FFFF);
            else begin
              mon_e = ack_q.pop_front();
              check("ack_inst",  32'(i),   32'(mon_e.inst));
              check("ack_port",  32'(p),   32'(mon_e.port));
              check("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
              if (!mon_e.we) shadow[i][p] = mon_e.rdata;
              check("rdata_granted", rdata[i][p],     shadow[i][p]);
              check("rdata_other",   rdata[i][1 - p], shadow[i][1 - p]);
            end
          end
        end
      end
    end
  end

  task automatic push_txn(input int i, input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int en_c, input int ack_c, input bit has_ack);
    txn_t t;
    t.inst = i; t.port = p; t.we = w; t.addr = a; t.wdata = wd; t.rdata = rd;
    t.en_cyc = en_c; t.ack_cyc = ack_c;
    cmd_q.push_back(t);
    if (has_ack) ack_q.push_back(t);
  endtask

  task automatic do_req(input int i, input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input int delay);
    bit got = 1'b0;
    repeat (delay) @(negedge clk);
    req[i][p] = 1'b1; we[i][p] = w; addr[i][p] = a; wdata[i][p] = wd;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ack[i][p]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    req[i][p] = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_quiet(input int i, input string tag);
    check({tag, "_busy"},     32'(busy[i]),   32'd0);
    check({tag, "_c_ack"},    32'(ack[i][0]), 32'd0);
    check({tag, "_d_ack"},    32'(ack[i][1]), 32'd0);
    check({tag, "_mem_en"},   32'(mem_en[i]), 32'd0);
    check({tag, "_mem_we"},   32'(mem_we[i]), 32'd0);
    check({tag, "_mem_addr"}, mem_addr[i],    32'd0);
    check({tag, "_mem_wdata"},mem_wdata[i],   32'd0);
    check({tag, "_c_rdata"},  rdata[i][0],    32'd0);
    check({tag, "_d_rdata"},  rdata[i][1],    32'd0);
  endtask

  int base;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
      end
    end
    repeat (3) @(negedge clk);
    check_quiet(0, "reset0");
    check_quiet(1, "reset1");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    settle();

    // C read, MEM_LAT=1.
    @(negedge clk); base = cyc;
    push_txn(0, 0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, base + 1, base + 3, 1'b1);
    do_req(0, 0, 1'b0, 32'h10, '0, 0);
    settle();

    // D write, busy over cycles 1-2.
    @(negedge clk); base = cyc;
    push_txn(0, 1, 1'b1, 32'h20, 32'h1234_5678, '0, base + 1, base + 2, 1'b1);
    fork
      do_req(0, 1, 1'b1, 32'h20, 32'h1234_5678, 0);
      begin
        @(negedge clk); check("wr_busy_c1", 32'(busy[0]), 32'd1);
        @(negedge clk); check("wr_busy_c2", 32'(busy[0]), 32'd1);
        @(negedge clk); check("wr_busy_c3", 32'(busy[0]), 32'd0);
      end
    join
    settle();

    // D reads back the written word.
    @(negedge clk); base = cyc;
    push_txn(0, 1, 1'b0, 32'h20, '0, 32'h1234_5678, base + 1, base + 3, 1'b1);
    do_req(0, 1, 1'b0, 32'h20, '0, 0);
    settle();

    // Round-robin: both held, grants C,D,C,D.
    @(negedge clk); base = cyc;
    push_txn(0, 0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, base + 1,  base + 3,  1'b1);
    push_txn(0, 1, 1'b0, 32'h14, '0, 32'h1414_1414, base + 5,  base + 7,  1'b1);
    push_txn(0, 0, 1'b0, 32'h18, '0, 32'h1818_1818, base + 9,  base + 11, 1'b1);
    push_txn(0, 1, 1'b0, 32'h1C, '0, 32'h1C1C_1C1C, base + 13, base + 15, 1'b1);
    fork
      begin do_req(0, 0, 1'b0, 32'h10, '0, 0); do_req(0, 0, 1'b0, 32'h18, '0, 0); end
      begin do_req(0, 1, 1'b0, 32'h14, '0, 0); do_req(0, 1, 1'b0, 32'h1C, '0, 0); end
    join
    settle();

    // D arrives one cycle after C is granted and waits its turn.
    @(negedge clk); base = cyc;
    push_txn(0, 0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, base + 1, base + 3, 1'b1);
    push_txn(0, 1, 1'b0, 32'h20, '0, 32'h1234_5678, base + 5, base + 7, 1'b1);
    fork
      do_req(0, 0, 1'b0, 32'h10, '0, 0);
      do_req(0, 1, 1'b0, 32'h20, '0, 1);
    join
    settle();

    // MEM_LAT=3 C read: only the cycle-4 data may be captured.
    @(negedge clk); base = cyc;
    push_txn(1, 0, 1'b0, 32'h40, '0, 32'hCAFE_F00D, base + 1, base + 5, 1'b1);
    do_req(1, 0, 1'b0, 32'h40, '0, 0);
    settle();

    // CPU priority: C wins every tie while it keeps requesting.
    @(negedge clk); base = cyc;
    push_txn(1, 0, 1'b0, 32'h44, '0, 32'h4444_4444, base + 1,  base + 5,  1'b1);
    push_txn(1, 0, 1'b0, 32'h4C, '0, 32'h4C4C_4C4C, base + 7,  base + 11, 1'b1);
    push_txn(1, 1, 1'b0, 32'h48, '0, 32'h4848_4848, base + 13, base + 17, 1'b1);
    fork
      begin do_req(1, 0, 1'b0, 32'h44, '0, 0); do_req(1, 0, 1'b0, 32'h4C, '0, 0); end
      do_req(1, 1, 1'b0, 32'h48, '0, 0);
    join
    settle();

    // Reset during WAIT of a D read: the issue happens, the ack never does.
    @(negedge clk); base = cyc;
    push_txn(1, 1, 1'b0, 32'h48, '0, '0, base + 1, 0, 1'b0);
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 32'h48;
    repeat (2) @(negedge clk);
    rst[1] = 1'b1;
    req[1][1] = 1'b0;
    @(negedge clk);
    check_quiet(1, "midrst");
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) @(negedge clk);

    // Normal timing resumes after the reset.
    @(negedge clk); base = cyc;
    push_txn(1, 0, 1'b0, 32'h40, '0, 32'hCAFE_F00D, base + 1, base + 5, 1'b1);
    do_req(1, 0, 1'b0, 32'h40, '0, 0);
    settle();

    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
